// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Multi-cycle sequencing controller for a shared-memory,
//                shared-ALU MIPS datapath. Walks each instruction through
//                fetch/decode/execute/memory/write-back, drives every mux
//                select and write strobe, stalls on mem_ready and traps
//                undefined opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] instr_op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwrite_cond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       w_pcwrite;
    logic       w_pcwrite_cond;
    logic       w_iord;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_memtoreg;
    logic       w_regdst;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [1:0] w_pcsource;
    logic       w_retire;
    logic       w_illegal;

    // State register; reset parks the controller in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath control decode; everything defaults to 0.
    always_comb begin
        w_next         = S_FETCH;
        w_pcwrite      = 1'b0;
        w_pcwrite_cond = 1'b0;
        w_iord         = 1'b0;
        w_memread      = 1'b0;
        w_memwrite     = 1'b0;
        w_irwrite      = 1'b0;
        w_memtoreg     = 1'b0;
        w_regdst       = 1'b0;
        w_regwrite     = 1'b0;
        w_alusrca      = 1'b0;
        w_alusrcb      = 2'b00;
        w_aluop        = 2'b00;
        w_pcsource     = 2'b00;
        w_retire       = 1'b0;
        w_illegal      = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_alusrcb = 2'b01;
                // IR load and PC+4 only commit once the fetch read lands.
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                case (instr_op)
                    c_OP_LW,
                    c_OP_SW:    w_next = S_MEMADR;
                    c_OP_RTYPE: w_next = S_EXEC;
                    c_OP_BEQ:   w_next = S_BRANCH;
                    c_OP_J:     w_next = S_JUMP;
                    default:    w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = (instr_op == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
                w_next    = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
                // A store retires in the cycle the write is accepted.
                w_retire   = mem_ready;
                w_next     = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
                w_next    = S_RWB;
            end
            S_RWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                w_alusrca      = 1'b1;
                w_aluop        = 2'b01;
                w_pcwrite_cond = 1'b1;
                w_pcsource     = 2'b01;
                w_retire       = 1'b1;
                w_next         = S_FETCH;
            end
            S_JUMP: begin
                w_pcwrite  = 1'b1;
                w_pcsource = 2'b10;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_TRAP: begin
                w_illegal = 1'b1;
                w_next    = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset holds the state at FETCH, whose decode would otherwise present
    // memread; gating with rst_n keeps every strobe low while reset is held.
    assign pcwrite      = rst_n & w_pcwrite;
    assign pcwrite_cond = rst_n & w_pcwrite_cond;
    assign iord         = rst_n & w_iord;
    assign memread      = rst_n & w_memread;
    assign memwrite     = rst_n & w_memwrite;
    assign irwrite      = rst_n & w_irwrite;
    assign memtoreg     = rst_n & w_memtoreg;
    assign regdst       = rst_n & w_regdst;
    assign regwrite     = rst_n & w_regwrite;
    assign alusrca      = rst_n & w_alusrca;
    assign alusrcb      = {2{rst_n}} & w_alusrcb;
    assign aluop        = {2{rst_n}} & w_aluop;
    assign pcsource     = {2{rst_n}} & w_pcsource;
    assign retire       = rst_n & w_retire;
    assign illegal      = rst_n & w_illegal;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_multicycle_ctrl
//  Description : Self-checking bench for mips_multicycle_ctrl. Directed
//                per-cycle vectors push expected control words into a queue;
//                a monitor pops and compares them every falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] c_R   = 6'b000000;
    localparam logic [5:0] c_LW  = 6'b100011;
    localparam logic [5:0] c_SW  = 6'b101011;
    localparam logic [5:0] c_BEQ = 6'b000100;
    localparam logic [5:0] c_J   = 6'b000010;
    localparam logic [5:0] c_BAD = 6'b111111;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwrite_cond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       retire;
        logic       illegal;
        logic [3:0] state;
    } row_t;

    typedef struct packed {
        int   idx;
        row_t exp;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] instr_op;
    logic       mem_ready;
    row_t       act;

    item_t      q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_vec    = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_op     (instr_op),
        .mem_ready    (mem_ready),
        .pcwrite      (act.pcwrite),
        .pcwrite_cond (act.pcwrite_cond),
        .iord         (act.iord),
        .memread      (act.memread),
        .memwrite     (act.memwrite),
        .irwrite      (act.irwrite),
        .memtoreg     (act.memtoreg),
        .regdst       (act.regdst),
        .regwrite     (act.regwrite),
        .alusrca      (act.alusrca),
        .alusrcb      (act.alusrcb),
        .aluop        (act.aluop),
        .pcsource     (act.pcsource),
        .retire       (act.retire),
        .illegal      (act.illegal),
        .state        (act.state)
    );

    // Expected control word for a given state, taken from the state table.
    function automatic row_t spec_row(input logic [3:0] st, input logic mr);
        row_t r;
        r = '0;
        r.state = st;
        case (st)
            4'd0:  begin r.memread = 1; r.alusrcb = 2'b01; r.irwrite = mr; r.pcwrite = mr; end
            4'd1:  begin r.alusrcb = 2'b11; end
            4'd2:  begin r.alusrca = 1; r.alusrcb = 2'b10; end
            4'd3:  begin r.memread = 1; r.iord = 1; end
            4'd4:  begin r.regwrite = 1; r.memtoreg = 1; r.retire = 1; end
            4'd5:  begin r.memwrite = 1; r.iord = 1; r.retire = mr; end
            4'd6:  begin r.alusrca = 1; r.aluop = 2'b10; end
            4'd7:  begin r.regdst = 1; r.regwrite = 1; r.retire = 1; end
            4'd8:  begin r.alusrca = 1; r.aluop = 2'b01; r.pcwrite_cond = 1;
                         r.pcsource = 2'b01; r.retire = 1; end
            4'd9:  begin r.pcwrite = 1; r.pcsource = 2'b10; r.retire = 1; end
            4'd10: begin r.illegal = 1; end
            default: r = '0;
        endcase
        return r;
    endfunction

    // One stimulus cycle: drive inputs just after the rising edge and queue
    // what the outputs must look like for the rest of that cycle.
    task automatic cyc(input logic rn, input logic [5:0] op, input logic mr,
                       input logic [3:0] es);
        item_t it;
        @(posedge clk);
        #1;
        rst_n     = rn;
        instr_op  = op;
        mem_ready = mr;
        it.idx = n_vec;
        it.exp = rn ? spec_row(es, mr) : row_t'(0);
        q.push_back(it);
        n_vec++;
    endtask

    // Monitor: compare the queued expectation mid-cycle, plus invariants.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            it = q.pop_front();
            n_checks++;
            if (act !== it.exp) begin
                n_errors++;
                $display("FAIL vec%0d ctrl_word: got %h expected %h (state got %0d expected %0d)",
                         it.idx, act, it.exp, act.state, it.exp.state);
            end
            n_checks++;
            if (act.retire && act.illegal) begin
                n_errors++;
                $display("FAIL vec%0d retire_illegal_excl: got retire=%b illegal=%b expected not both",
                         it.idx, act.retire, act.illegal);
            end
            n_checks++;
            if (act.pcwrite && act.pcwrite_cond) begin
                n_errors++;
                $display("FAIL vec%0d pcwrite_excl: got pcwrite=%b pcwrite_cond=%b expected not both",
                         it.idx, act.pcwrite, act.pcwrite_cond);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        instr_op  = 6'd0;
        mem_ready = 1'b1;

        // Reset held with mem_ready high: everything zero.
        cyc(0, c_R, 1, 0);
        cyc(0, c_R, 1, 0);
        // Release, stall the first fetch, then fetch.
        cyc(1, c_R, 0, 0);
        cyc(1, c_R, 0, 0);
        cyc(1, c_R, 1, 0);
        // lw: 1,2,3,4 then fetch.
        cyc(1, c_LW, 1, 1);
        cyc(1, c_LW, 1, 2);
        cyc(1, c_R,  1, 3);
        cyc(1, c_R,  1, 4);
        cyc(1, c_R,  1, 0);
        // lw again, reset asserted while in MEMRD with mem_ready=1.
        cyc(1, c_LW, 1, 1);
        cyc(1, c_LW, 1, 2);
        cyc(1, c_R,  0, 3);
        cyc(0, c_R,  1, 0);
        cyc(0, c_R,  1, 0);
        cyc(1, c_R,  0, 0);
        cyc(1, c_R,  0, 0);
        cyc(1, c_R,  1, 0);
        // sw with three stall cycles in MEMWR.
        cyc(1, c_SW, 1, 1);
        cyc(1, c_SW, 1, 2);
        cyc(1, c_R,  0, 5);
        cyc(1, c_R,  0, 5);
        cyc(1, c_R,  0, 5);
        cyc(1, c_R,  1, 5);
        cyc(1, c_R,  1, 0);
        // R-format then beq.
        cyc(1, c_R,   1, 1);
        cyc(1, c_R,   1, 6);
        cyc(1, c_R,   1, 7);
        cyc(1, c_R,   1, 0);
        cyc(1, c_BEQ, 1, 1);
        cyc(1, c_R,   1, 8);
        cyc(1, c_R,   1, 0);
        // j.
        cyc(1, c_J, 1, 1);
        cyc(1, c_R, 1, 9);
        cyc(1, c_R, 1, 0);
        // Illegal opcode.
        cyc(1, c_BAD, 1, 1);
        cyc(1, c_R,   1, 10);
        // Fetch stalled for five cycles, then completes.
        for (int i = 0; i < 5; i++) cyc(1, c_BAD, 0, 0);
        cyc(1, c_R, 1, 0);
        // j after the stalled fetch.
        cyc(1, c_J, 1, 1);
        cyc(1, c_R, 1, 9);
        cyc(1, c_R, 1, 0);

        // Let the monitor drain the last entry.
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
